// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter.
// Holds the default widths, the source encoding used by the round-robin
// pointer, and the writeback request record.
package wb_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int AW_DEFAULT    = 5;
    localparam int CNT_W_DEFAULT = 16;

    // Source identifier; the value doubles as the bit index in a grant vector.
    typedef enum logic {
        WB_SRC_LSU = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_e;

    // One writeback request at the default widths.
    typedef struct packed {
        logic [AW_DEFAULT-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_req_t;

    // The source that was not named; used when the pointer hands over.
    function automatic wb_src_e wb_other(input wb_src_e s);
        return (s == WB_SRC_LSU) ? WB_SRC_ALU : WB_SRC_LSU;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way round-robin picker for the writeback port.
// Grants the only valid source, or the pointed-to source when both are
// valid; in that case the pointer moves to the loser so it wins next time.
// The pointer flop lives here and comes out of reset pointing at the LSU.
module wb_rr_pick
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_valid,
    input  logic       lsu_valid,
    output logic [1:0] gnt,
    output wb_src_e    ptr_nxt
);

    wb_src_e ptr;

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= WB_SRC_LSU;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    // Pointer only moves when both sources compete
    always_comb begin
        ptr_nxt = ptr;
        if (alu_valid && lsu_valid) begin
            ptr_nxt = wb_other(ptr);
        end
    end

    // One-hot grant, indexed by source encoding
    always_comb begin
        gnt = 2'b00;
        unique case ({alu_valid, lsu_valid})
            2'b10:   gnt[WB_SRC_ALU] = 1'b1;
            2'b01:   gnt[WB_SRC_LSU] = 1'b1;
            2'b11:   gnt[ptr]        = 1'b1;
            default: gnt             = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single regfile
// write port (we3/wa3/wd3) through one output register, and counts the
// cycles in which both producers competed (saturating).
// Optional feature macro: WB_BYPASS_EN adds a same-cycle forwarding
// compare against the registered write for two read addresses.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_rd,
    input  logic [XLEN-1:0]  alu_data,

    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,

    output logic             we3,
    output logic [AW-1:0]    wa3,
    output logic [XLEN-1:0]  wd3,

`ifdef WB_BYPASS_EN
    input  logic [AW-1:0]    byp_ra1,
    input  logic [AW-1:0]    byp_ra2,
    output logic             byp_hit1,
    output logic             byp_hit2,
    output logic [XLEN-1:0]  byp_data1,
    output logic [XLEN-1:0]  byp_data2,
`endif

    output logic [CNT_W-1:0] busy_cnt
);

    // Count up by one, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]      gnt;
    wb_src_e         unused_ptr_nxt;
    logic            vld_p0;
    logic [AW-1:0]   rd_p0;
    logic [XLEN-1:0] data_p0;

    wb_rr_pick u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .gnt       (gnt),
        .ptr_nxt   (unused_ptr_nxt)
    );

    assign alu_ready = gnt[WB_SRC_ALU];
    assign lsu_ready = gnt[WB_SRC_LSU];

    // Stage p0: steer the granted request (ALU by default when nothing wins)
    always_comb begin
        vld_p0  = |gnt;
        rd_p0   = alu_rd;
        data_p0 = alu_data;
        if (gnt[WB_SRC_LSU]) begin
            rd_p0   = lsu_rd;
            data_p0 = lsu_data;
        end
    end

    // Stage p1: write-port register; rd 0 is accepted but never enables a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= vld_p0 && (rd_p0 != '0);
            if (vld_p0) begin
                wa3 <= rd_p0;
                wd3 <= data_p0;
            end
        end
    end

    // Contention counter: one tick per edge with both producers valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (alu_valid && lsu_valid) begin
            busy_cnt <= sat_inc(busy_cnt);
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the registered write to readers until the regfile absorbs it
    always_comb begin
        byp_hit1  = we3 && (wa3 == byp_ra1) && (byp_ra1 != '0);
        byp_hit2  = we3 && (wa3 == byp_ra2) && (byp_ra2 != '0);
        byp_data1 = wd3;
        byp_data2 = wd3;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus
// randomized producers, all checked every cycle against a behavioural model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [15:0] busy_cnt;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_ra1, byp_ra2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
`ifdef WB_BYPASS_EN
        .byp_ra1   (byp_ra1),
        .byp_ra2   (byp_ra2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2),
`endif
        .busy_cnt  (busy_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected port contents, contention count, and
    // which source wins the next tie (true = ALU).
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_cnt;
    bit          m_tie_alu;

    // Model check + update, on the falling edge when all inputs are settled
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                chk("rst_we3", 32'(we3), 32'd0);
                chk("rst_busy", 32'(busy_cnt), 32'd0);
                m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_cnt = 0; m_tie_alu = 1'b0;
            end else begin
                int winner; // 0 none, 1 ALU, 2 LSU
                if (alu_valid && lsu_valid) winner = m_tie_alu ? 1 : 2;
                else if (alu_valid)         winner = 1;
                else if (lsu_valid)         winner = 2;
                else                        winner = 0;

                chk("alu_ready", 32'(alu_ready), 32'(winner == 1));
                chk("lsu_ready", 32'(lsu_ready), 32'(winner == 2));
                chk("we3", 32'(we3), 32'(m_we));
                chk("wa3", 32'(wa3), 32'(m_wa));
                chk("wd3", wd3, m_wd);
                chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
`ifdef WB_BYPASS_EN
                chk("byp_hit1", 32'(byp_hit1), 32'(m_we && m_wa == byp_ra1 && byp_ra1 != 5'd0));
                chk("byp_hit2", 32'(byp_hit2), 32'(m_we && m_wa == byp_ra2 && byp_ra2 != 5'd0));
                chk("byp_data1", byp_data1, m_wd);
                chk("byp_data2", byp_data2, m_wd);
`endif
                if (alu_valid && lsu_valid) begin
                    m_tie_alu = (winner == 2);
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
                if (winner == 1) begin
                    m_we = (alu_rd != 5'd0); m_wa = alu_rd; m_wd = alu_data;
                end else if (winner == 2) begin
                    m_we = (lsu_rd != 5'd0); m_wa = lsu_rd; m_wd = lsu_data;
                end else begin
                    m_we = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random producers: a new result appears only after the previous one was taken
    task automatic run_random(input int n);
        bit acc_a, acc_l;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            step();
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom);
                alu_data  = $urandom;
            end
            if (!lsu_valid || acc_l) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = 5'($urandom);
                lsu_data  = $urandom;
            end
`ifdef WB_BYPASS_EN
            byp_ra1 = 5'($urandom);
            byp_ra2 = ($urandom_range(0, 1) != 0) ? wa3 : 5'($urandom);
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
`ifdef WB_BYPASS_EN
        byp_ra1 = 5'd0; byp_ra2 = 5'd0;
`endif
        chk_en = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("init_we3", 32'(we3), 32'd0);
        chk("init_wa3", 32'(wa3), 32'd0);
        chk("init_wd3", wd3, 32'd0);
        step();
        rst_n = 1'b1;

        // ALU only
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("alu_only_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_only_we3", 32'(we3), 32'd1);
        chk("alu_only_wa3", 32'(wa3), 32'd5);
        chk("alu_only_wd3", wd3, 32'hDEADBEEF);
        @(negedge clk);
        chk("alu_only_we3_drop", 32'(we3), 32'd0);

        // Contention: LSU, ALU, LSU
        step();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11111111;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22222222;
        @(negedge clk);
        chk("cont1_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("cont1_alu_ready", 32'(alu_ready), 32'd0);
        step();
        @(negedge clk);
        chk("cont2_alu_ready", 32'(alu_ready), 32'd1);
        chk("cont2_wa3", 32'(wa3), 32'd2);
        step();
        @(negedge clk);
        chk("cont3_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("cont3_wa3", 32'(wa3), 32'd1);
        chk("cont3_wd3", wd3, 32'h11111111);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        chk("cont_final_wa3", 32'(wa3), 32'd2);
        chk("cont_busy_cnt", 32'(busy_cnt), 32'd3);

        // Zero register: accepted, never written
        step();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h12345678;
        @(negedge clk);
        chk("zero_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("zero_we3_a", 32'(we3), 32'd0);
        step();
        lsu_valid = 1'b0;
        @(negedge clk);
        chk("zero_we3_b", 32'(we3), 32'd0);
        @(negedge clk);
        chk("zero_we3_c", 32'(we3), 32'd0);

        // Asynchronous reset in the middle of a write
        step();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFEF00D;
        step();
        alu_valid = 1'b0;
        #1;
        chk("midrst_we3_before", 32'(we3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we3", 32'(we3), 32'd0);
        chk("midrst_wa3", 32'(wa3), 32'd0);
        chk("midrst_wd3", wd3, 32'd0);
        chk("midrst_busy", 32'(busy_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2;
        @(negedge clk);
        chk("postrst_ptr_lsu", 32'(lsu_ready), 32'd1);
        step();
        lsu_valid = 1'b0;
        @(negedge clk);
        chk("postrst_alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;

`ifdef WB_BYPASS_EN
        // Forwarding from the registered write
        step();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5A5A5A5;
        step();
        alu_valid = 1'b0; byp_ra1 = 5'd7; byp_ra2 = 5'd0;
        @(negedge clk);
        chk("byp_hit1_lit", 32'(byp_hit1), 32'd1);
        chk("byp_data1_lit", byp_data1, 32'hA5A5A5A5);
        chk("byp_hit2_lit", 32'(byp_hit2), 32'd0);
`endif

        // Randomized traffic
        run_random(3000);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;

        // Counter saturation
        step();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA0000;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h0000BBBB;
        repeat (65541) @(posedge clk);
        @(negedge clk);
        chk("sat_busy", 32'(busy_cnt), 32'h0000FFFF);
        @(negedge clk);
        chk("sat_busy_hold", 32'(busy_cnt), 32'h0000FFFF);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
